alu_byte_sequencer: RTL

Upstream/downstream wrapper for the 8-bit ALU. Executes one multi-byte operation (8*BYTES bits) by streaming operand bytes LSB-first through the ALU, one byte per cycle, chaining carry between bytes. Result, carry and zero flag are captured into a result register with a valid/ready handshake. Sits between the command source (controller/register file) and the ALU; the ALU itself stays combinational and external.

---
 rtl/alu_byte_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_byte_sequencer.sv
// Runs one 8*BYTES-bit operation through an external 8-bit ALU, one byte per cycle, LSB first.
// Optional signed-overflow output res_ovf: define ALU_SEQ_OVF_EN.
module alu_byte_sequencer #(
  parameter int BYTES = 4,
  localparam int W = 8 * BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_cin,
  output logic [2:0]   alu_oper,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_c_in,
  input  logic [7:0]   alu_sum,
  input  logic         alu_c_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_carry,
  output logic         res_zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic         res_ovf
`endif
);

  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [W-1:0]  a_q, b_q;
  logic          cin_q;
  logic [KW-1:0] k_q;
  logic          is_logic;
  logic          last_byte;
  logic [W-1:0]  res_shift;

  assign is_logic  = op_q[2] | (op_q[1] & op_q[0]);
  assign last_byte = (k_q == K_LAST);
  // Operands shift down and the result shifts in from the top, so after BYTES
  // steps byte 0 sits in the LSBs without any variable part-selects.
  assign res_shift = (res_data >> 8) | (W'(alu_sum) << (W - 8));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    alu_oper  = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_c_in  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = RUN;
      end
      RUN: begin
        alu_oper = op_q;
        alu_a    = a_q[7:0];
        alu_b    = b_q[7:0];
        // res_carry doubles as the inter-byte carry; b-a wants it inverted
        // because the ALU inverts c_in for that op.
        if (is_logic)            alu_c_in = 1'b0;
        else if (k_q == '0)      alu_c_in = cin_q;
        else if (op_q == 3'b010) alu_c_in = ~res_carry;
        else                     alu_c_in = res_carry;
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      k_q       <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      res_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            a_q   <= cmd_a;
            b_q   <= cmd_b;
            cin_q <= cmd_cin;
            k_q   <= '0;
          end
        end
        RUN: begin
          a_q       <= a_q >> 8;
          b_q       <= b_q >> 8;
          k_q       <= k_q + KW'(1);
          res_data  <= res_shift;
          res_carry <= is_logic ? 1'b0 : alu_c_out;
          if (last_byte) begin
            res_zero <= (res_shift == '0);
`ifdef ALU_SEQ_OVF_EN
            case (op_q)
              3'b000:  res_ovf <= (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
              3'b001:  res_ovf <= (alu_a[7] != alu_b[7]) && (alu_sum[7] != alu_a[7]);
              3'b010:  res_ovf <= (alu_a[7] != alu_b[7]) && (alu_sum[7] != alu_b[7]);
              default: res_ovf <= 1'b0;
            endcase
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
